custom_sync_fifo_prog: RTL and testbench



---
 rtl/custom_fifo_pkg.sv | 14 +
 rtl/custom_sync_fifomem.sv | 28 ++
 rtl/custom_sync_fifo_prog.sv | 149 ++++++++++++++
 tb/tb_custom_sync_fifo_prog.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/custom_fifo_pkg.sv
// Shared constants, pointer type and depth helper for the programmable single-clock FIFO.
package custom_fifo_pkg;

    localparam int DEFAULT_DATASIZE = 8;
    localparam int DEFAULT_ADDRSIZE = 4;

    // One extra MSB over the address distinguishes a full FIFO from an empty one.
    typedef logic [DEFAULT_ADDRSIZE:0] fifo_ptr_t;

    function automatic int fifo_depth(input int addrsize);
        return 1 << addrsize;
    endfunction

endpackage

// File: rtl/custom_sync_fifomem.sv
// Dual-port FIFO storage: one synchronous write port, one combinational read port.
module custom_sync_fifomem
    import custom_fifo_pkg::*;
#(
    parameter int DATASIZE = DEFAULT_DATASIZE,
    parameter int ADDRSIZE = DEFAULT_ADDRSIZE
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [ADDRSIZE-1:0] waddr_i,
    input  logic [DATASIZE-1:0] wdata_i,
    input  logic [ADDRSIZE-1:0] raddr_i,
    output logic [DATASIZE-1:0] rdata_o
);

    localparam int DEPTH = fifo_depth(ADDRSIZE);

    logic [DATASIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/custom_sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/empty, occupancy count, sticky errors and flush.
// Define CUSTOM_FIFO_FWFT_EN for first-word-fall-through read data; otherwise dout is registered.
module custom_sync_fifo_prog
    import custom_fifo_pkg::*;
#(
    parameter int DATASIZE = DEFAULT_DATASIZE,
    parameter int ADDRSIZE = DEFAULT_ADDRSIZE
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                wen,
    input  logic                ren,
    input  logic [DATASIZE-1:0] din,
    input  logic                flush_i,
    input  logic                clr_err_i,
    input  logic [ADDRSIZE:0]   af_thresh_i,
    input  logic [ADDRSIZE:0]   ae_thresh_i,
    output logic [DATASIZE-1:0] dout,
    output logic                fifo_full,
    output logic                fifo_empty,
    output logic                fifo_almost_full,
    output logic                fifo_almost_empty,
    output logic [ADDRSIZE:0]   fifo_count,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = fifo_depth(ADDRSIZE);
    localparam int PW    = ADDRSIZE + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          wr_accept;
    logic          rd_accept;
    logic [DATASIZE-1:0] mem_rdata;

    // Accept decisions use the registered flags so they never depend on this cycle's update.
    assign wr_accept = wen && !full_q;
    assign rd_accept = ren && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        full_d   = full_q;
        empty_d  = empty_q;
        af_d     = af_q;
        ae_d     = ae_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            full_d   = 1'b0;
            empty_d  = 1'b1;
            af_d     = 1'b0;
            ae_d     = 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(wr_accept);
            rd_ptr_d = rd_ptr_q + PW'(rd_accept);
            count_d  = count_q + PW'(wr_accept) - PW'(rd_accept);
            full_d   = (count_d == PW'(DEPTH));
            empty_d  = (count_d == '0);
            af_d     = (count_d >= af_thresh_i);
            ae_d     = (count_d <= ae_thresh_i);
            // A new error outranks a simultaneous clear.
            if (wen && full_q) begin
                ovf_d = 1'b1;
            end else if (clr_err_i) begin
                ovf_d = 1'b0;
            end
            if (ren && empty_q) begin
                unf_d = 1'b1;
            end else if (clr_err_i) begin
                unf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    custom_sync_fifomem #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_accept && !flush_i),
        .waddr_i (wr_ptr_q[ADDRSIZE-1:0]),
        .wdata_i (din),
        .raddr_i (rd_ptr_q[ADDRSIZE-1:0]),
        .rdata_o (mem_rdata)
    );

`ifdef CUSTOM_FIFO_FWFT_EN
    // Head word is presented directly; meaningless while empty.
    assign dout = mem_rdata;
`else
    logic [DATASIZE-1:0] dout_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dout_q <= '0;
        end else if (rd_accept && !flush_i) begin
            dout_q <= mem_rdata;
        end
    end

    assign dout = dout_q;
`endif

    assign fifo_full         = full_q;
    assign fifo_empty        = empty_q;
    assign fifo_almost_full  = af_q;
    assign fifo_almost_empty = ae_q;
    assign fifo_count        = count_q;
    assign overflow          = ovf_q;
    assign underflow         = unf_q;

endmodule

// File: tb/tb_custom_sync_fifo_prog.sv
// Self-checking bench for custom_sync_fifo_prog: directed scenarios plus random traffic against a queue model.
module tb_custom_sync_fifo_prog;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       wen = 1'b0;
    logic       ren = 1'b0;
    logic [7:0] din = 8'h00;
    logic       flush_i = 1'b0;
    logic       clr_err_i = 1'b0;
    logic [4:0] af_thresh_i = 5'd16;
    logic [4:0] ae_thresh_i = 5'd0;
    logic [7:0] dout;
    logic       fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty;
    logic [4:0] fifo_count;
    logic       overflow, underflow;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    logic [7:0] mq[$];
    logic       m_af = 1'b0;
    logic       m_ae = 1'b1;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] m_dout = 8'h00;

    always #5 clk_i = ~clk_i;

    custom_sync_fifo_prog #(.DATASIZE(8), .ADDRSIZE(4)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .wen               (wen),
        .ren               (ren),
        .din               (din),
        .flush_i           (flush_i),
        .clr_err_i         (clr_err_i),
        .af_thresh_i       (af_thresh_i),
        .ae_thresh_i       (ae_thresh_i),
        .dout              (dout),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_count        (fifo_count),
        .overflow          (overflow),
        .underflow         (underflow)
    );

    logic [10:0] dut_vec;
    assign dut_vec = {fifo_full, fifo_empty, fifo_almost_full, fifo_almost_empty,
                      fifo_count, overflow, underflow};

    function automatic logic [10:0] exp_vec();
        return {mq.size() == 16, mq.size() == 0, m_af, m_ae, 5'(mq.size()), m_ovf, m_unf};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_af = 1'b0;
        m_ae = 1'b1;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_dout = 8'h00;
    endtask

    // One clock cycle of stimulus; the model advances from the FIFO rules at the edge.
    task automatic tick(input logic w, input logic r, input logic [7:0] d,
                        input logic f, input logic c);
        bit was_full, was_empty;
        wen = w; ren = r; din = d; flush_i = f; clr_err_i = c;
        @(posedge clk_i);
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        if (f) begin
            mq.delete();
            m_af = 1'b0;
            m_ae = 1'b1;
        end else begin
            if (r && !was_empty) m_dout = mq.pop_front();
            if (w && !was_full) mq.push_back(d);
            if (w && was_full) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            if (r && was_empty) m_unf = 1'b1;
            else if (c) m_unf = 1'b0;
            m_af = (mq.size() >= int'(af_thresh_i));
            m_ae = (mq.size() <= int'(ae_thresh_i));
        end
        #1;
        wen = 1'b0; ren = 1'b0; flush_i = 1'b0; clr_err_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        tests_run++;
        if (dut_vec !== 11'b01_01_00000_00) begin
            $display("FAIL reset_flags: got %b expected %b", dut_vec, 11'b01_01_00000_00);
            tests_failed++;
        end
        tests_run++;
        if (dout !== 8'h00) begin
            $display("FAIL reset_dout: got %h expected 00", dout);
            tests_failed++;
        end
        rst_n_i = 1'b1;
        model_reset();
        $display("[TB] reset checked");
    endtask

    task automatic test_fill_overflow_drain();
        for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        tests_run++;
        if (fifo_full !== 1'b1 || fifo_count !== 5'd16) begin
            $display("FAIL fill_full: full=%b count=%0d expected full=1 count=16", fifo_full, fifo_count);
            tests_failed++;
        end
        tick(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        tests_run++;
        if (overflow !== 1'b1 || fifo_count !== 5'd16) begin
            $display("FAIL overflow: ovf=%b count=%0d expected ovf=1 count=16", overflow, fifo_count);
            tests_failed++;
        end
        for (int i = 0; i < 16; i++) begin
`ifdef CUSTOM_FIFO_FWFT_EN
            tests_run++;
            if (dout !== 8'(i)) begin
                $display("FAIL drain_data[%0d]: got %h expected %h", i, dout, 8'(i));
                tests_failed++;
            end
            tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
`else
            tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            tests_run++;
            if (dout !== 8'(i)) begin
                $display("FAIL drain_data[%0d]: got %h expected %h", i, dout, 8'(i));
                tests_failed++;
            end
`endif
        end
        tests_run++;
        if (fifo_empty !== 1'b1 || dut_vec !== exp_vec()) begin
            $display("FAIL drain_empty: got %b expected %b", dut_vec, exp_vec());
            tests_failed++;
        end
        $display("[TB] fill/overflow/drain done");
    endtask

    task automatic test_underflow_clr();
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        tests_run++;
        if (fifo_count !== 5'd1 || underflow !== 1'b1) begin
            $display("FAIL empty_wr_rd: count=%0d unf=%b expected count=1 unf=1", fifo_count, underflow);
            tests_failed++;
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (underflow !== 1'b0) begin
            $display("FAIL clr_err: unf=%b expected 0", underflow);
            tests_failed++;
        end
        tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
`ifndef CUSTOM_FIFO_FWFT_EN
        tests_run++;
        if (dout !== 8'h55) begin
            $display("FAIL read_55: got %h expected 55", dout);
            tests_failed++;
        end
`endif
        tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        tests_run++;
        if (underflow !== 1'b1) begin
            $display("FAIL set_wins: unf=%b expected 1", underflow);
            tests_failed++;
        end
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        $display("[TB] underflow/clear done");
    endtask

    task automatic test_thresholds();
        af_thresh_i = 5'd12;
        ae_thresh_i = 5'd3;
        for (int k = 1; k <= 16; k++) begin
            tick(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
            tests_run++;
            if (fifo_almost_empty !== (k <= 3) || fifo_almost_full !== (k >= 12)) begin
                $display("FAIL thresh_fill[%0d]: ae=%b af=%b expected ae=%b af=%b",
                         k, fifo_almost_empty, fifo_almost_full, k <= 3, k >= 12);
                tests_failed++;
            end
        end
        for (int k = 15; k >= 0; k--) begin
            tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            tests_run++;
            if (fifo_almost_empty !== (k <= 3) || fifo_almost_full !== (k >= 12)) begin
                $display("FAIL thresh_drain[%0d]: ae=%b af=%b expected ae=%b af=%b",
                         k, fifo_almost_empty, fifo_almost_full, k <= 3, k >= 12);
                tests_failed++;
            end
        end
        $display("[TB] thresholds done");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
`ifdef CUSTOM_FIFO_FWFT_EN
            tests_run++;
            if (dout !== mq[0]) begin
                $display("FAIL b2b_data[%0d]: got %h expected %h", i, dout, mq[0]);
                tests_failed++;
            end
`endif
            tick(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
            tests_run++;
            if (fifo_count !== 5'd8 || dut_vec !== exp_vec()) begin
                $display("FAIL b2b_count[%0d]: got %b expected %b", i, dut_vec, exp_vec());
                tests_failed++;
            end
`ifndef CUSTOM_FIFO_FWFT_EN
            tests_run++;
            if (dout !== m_dout) begin
                $display("FAIL b2b_data[%0d]: got %h expected %h", i, dout, m_dout);
                tests_failed++;
            end
`endif
        end
        $display("[TB] back-to-back done");
    endtask

    task automatic test_flush();
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        tick(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
        tests_run++;
        if (fifo_count !== 5'd0 || fifo_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            $display("FAIL flush: count=%0d empty=%b ovf=%b unf=%b expected 0 1 0 0",
                     fifo_count, fifo_empty, overflow, underflow);
            tests_failed++;
        end
        tick(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        tests_run++;
        if (underflow !== 1'b0) begin
            $display("FAIL flush_no_unf: unf=%b expected 0", underflow);
            tests_failed++;
        end
        tick(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
`ifdef CUSTOM_FIFO_FWFT_EN
        tests_run++;
        if (dout !== 8'h3C) begin
            $display("FAIL flush_3c: got %h expected 3c", dout);
            tests_failed++;
        end
`endif
        tick(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
`ifndef CUSTOM_FIFO_FWFT_EN
        tests_run++;
        if (dout !== 8'h3C) begin
            $display("FAIL flush_3c: got %h expected 3c", dout);
            tests_failed++;
        end
`endif
        $display("[TB] flush done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                af_thresh_i = 5'($urandom_range(0, 18));
                ae_thresh_i = 5'($urandom_range(0, 18));
            end
            tick(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), 8'($urandom),
                 1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 10));
            tests_run++;
            if (dut_vec !== exp_vec()) begin
                $display("FAIL rand_flags[%0d]: got %b expected %b", i, dut_vec, exp_vec());
                tests_failed++;
            end
`ifdef CUSTOM_FIFO_FWFT_EN
            if (mq.size() != 0) begin
                tests_run++;
                if (dout !== mq[0]) begin
                    $display("FAIL rand_data[%0d]: got %h expected %h", i, dout, mq[0]);
                    tests_failed++;
                end
            end
`else
            tests_run++;
            if (dout !== m_dout) begin
                $display("FAIL rand_data[%0d]: got %h expected %h", i, dout, m_dout);
                tests_failed++;
            end
`endif
        end
        $display("[TB] random traffic done");
    endtask

    task automatic test_async_reset();
        af_thresh_i = 5'd2;
        ae_thresh_i = 5'd1;
        tick(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
        wen = 1'b1; din = 8'hC5;
        #2;
        rst_n_i = 1'b0;
        #1;
        tests_run++;
        if (dut_vec !== 11'b01_01_00000_00) begin
            $display("FAIL async_reset: got %b expected %b", dut_vec, 11'b01_01_00000_00);
            tests_failed++;
        end
`ifndef CUSTOM_FIFO_FWFT_EN
        tests_run++;
        if (dout !== 8'h00) begin
            $display("FAIL async_reset_dout: got %h expected 00", dout);
            tests_failed++;
        end
`endif
        wen = 1'b0;
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
        model_reset();
        #1;
        tests_run++;
        if (dut_vec !== exp_vec()) begin
            $display("FAIL post_reset: got %b expected %b", dut_vec, exp_vec());
            tests_failed++;
        end
`ifdef CUSTOM_FIFO_FWFT_EN
        tick(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        tests_run++;
        if (fifo_empty !== 1'b0 || dout !== 8'h77) begin
            $display("FAIL fwft_77: empty=%b dout=%h expected 0 77", fifo_empty, dout);
            tests_failed++;
        end
`endif
        $display("[TB] async reset done");
    endtask

    initial begin
        test_reset();
        test_fill_overflow_drain();
        test_underflow_clr();
        test_thresholds();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
